// File: rtl/tron_pkg.sv
// Shared types and constants for the background frame reader: FSM states,
// frame geometry and the per-background SRAM base addresses.
package tron_pkg;

  localparam int ADDR_W = 20;
  localparam int CNT_W  = 18;
  localparam int DATA_W = 16;

  // 640x480 pixels, two pixels per 16-bit SRAM word.
  localparam int BG_FRAME_WORDS = 153600;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_DONE
  } rd_state_t;

  localparam logic [ADDR_W-1:0] BG_BASE [4] = '{
    20'd0, 20'd153600, 20'd307200, 20'd460800
  };

  // Base address of background 'sel'; reduced geometries scale the same way.
  function automatic logic [ADDR_W-1:0] bg_base(input logic [1:0] sel,
                                                input int        frame_words);
    if (frame_words == BG_FRAME_WORDS) return BG_BASE[sel];
    return ADDR_W'(frame_words) * ADDR_W'(sel);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous word FIFO with zero-bubble head output: a word pushed on an edge
// is visible on head right after that edge. Pops on an empty FIFO are dropped.
module pixel_fifo
  import tron_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_W
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bg_frame_reader.sv
// Streams one background frame from SRAM into a pixel FIFO, one word every two
// cycles, stalling whenever the FIFO could not accept the next word.
module bg_frame_reader
  import tron_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int FRAME_WORDS = BG_FRAME_WORDS
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [1:0]        BG_Sel,
  output logic              reading,
  output logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              busy,
  output logic              frame_done,
  output logic              underflow
);

  localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  rd_state_t         state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  word_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     occupancy;
  logic              fifo_empty;
  logic              push;
  logic              pop_ok;
  logic              admit;
  logic              start_ok;

  assign start_ok  = start && (state == S_IDLE);
  assign push      = (state == S_CAPTURE);
  assign pop_ok    = pix_rd && !fifo_empty;
  assign busy      = (state != S_IDLE);
  assign pix_valid = !fifo_empty;

  // No read is outstanding while in ISSUE, so the only pending change to the
  // FIFO before the issued word lands is this edge's pop.
  assign occupancy = fifo_count - CW'(pop_ok);
  assign admit     = (occupancy <= CW'(FIFO_DEPTH - 1));

  // NOTE: every register here is assigned with <= so all state updates on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      base       <= '0;
      word_cnt   <= '0;
      reading    <= 1'b0;
      ADDR       <= '0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= bg_base(BG_Sel, FRAME_WORDS);
            word_cnt <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (admit) begin
            reading <= 1'b1;
            ADDR    <= base + ADDR_W'(word_cnt);
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          reading  <= 1'b0;
          word_cnt <= word_cnt + CNT_W'(1);
          if (word_cnt == LAST_WORD) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky until reset or the next accepted start; a same-cycle empty pop wins.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                 underflow <= 1'b0;
    else if (pix_rd && fifo_empty) underflow <= 1'b1;
    else if (start_ok)            underflow <= 1'b0;
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (push),
    .push_data (DATA_IN),
    .pop       (pix_rd),
    .head      (pix_data),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bg_frame_reader.sv
// Randomised bench for bg_frame_reader: a queue-based model of the frame
// stream and FIFO, plus a full-geometry instance for the base-address table.
module tb_bg_frame_reader;

  localparam int DEPTH = 16;
  localparam int FW_A  = 40;

  logic        Clk;
  logic        Reset_n;
  logic        start, pix_rd;
  logic [1:0]  sel;
  logic        reading;
  logic [19:0] addr;
  logic [15:0] data_in, pix_data;
  logic        pix_valid, busy, frame_done, underflow;

  logic        start_d, pix_rd_d;
  logic [1:0]  sel_d;
  logic        reading_d;
  logic [19:0] addr_d;
  logic [15:0] data_in_d, pix_data_d;
  logic        pix_valid_d, busy_d, frame_done_d, underflow_d;

  logic [15:0] seed;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  logic [15:0] q[$];
  bit          m_busy, m_done, m_uf, tput_mode, saw_read;
  int          m_base, m_issued, m_pushed, m_frames;
  logic [19:0] m_addr;
  int          cyc, last_read_cyc;

  function automatic logic [15:0] sram_word(input logic [19:0] a);
    return (a[15:0] * 16'h9E37) ^ {a[19:16], 12'h000} ^ seed;
  endfunction

  assign data_in   = sram_word(addr);
  assign data_in_d = sram_word(addr_d);

  bg_frame_reader #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FW_A)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .BG_Sel(sel),
    .reading(reading), .ADDR(addr), .DATA_IN(data_in), .pix_rd(pix_rd),
    .pix_data(pix_data), .pix_valid(pix_valid), .busy(busy),
    .frame_done(frame_done), .underflow(underflow)
  );

  bg_frame_reader dut_full (
    .Clk(Clk), .Reset_n(Reset_n), .start(start_d), .BG_Sel(sel_d),
    .reading(reading_d), .ADDR(addr_d), .DATA_IN(data_in_d), .pix_rd(pix_rd_d),
    .pix_data(pix_data_d), .pix_valid(pix_valid_d), .busy(busy_d),
    .frame_done(frame_done_d), .underflow(underflow_d)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_busy = 0; m_done = 0; m_uf = 0;
    m_issued = 0; m_pushed = 0; m_addr = '0;
  endtask

  task automatic reset_values();
    check("rst_reading",    reading,      0);
    check("rst_addr",       addr,         0);
    check("rst_busy",       busy,         0);
    check("rst_frame_done", frame_done,   0);
    check("rst_pix_valid",  pix_valid,    0);
    check("rst_pix_data",   pix_data,     0);
    check("rst_underflow",  underflow,    0);
    check("rst_full_read",  reading_d,    0);
    check("rst_full_addr",  addr_d,       0);
    check("rst_full_busy",  busy_d,       0);
    check("rst_full_done",  frame_done_d, 0);
    check("rst_full_valid", pix_valid_d,  0);
    check("rst_full_data",  pix_data_d,   0);
    check("rst_full_uf",    underflow_d,  0);
  endtask

  // One clock: compare outputs at the negedge, apply the next inputs, then
  // advance the model to what the following posedge must produce.
  task automatic cycle(input logic s, input logic [1:0] bs, input logic rd);
    bit          push_now;
    logic [15:0] push_word;
    @(negedge Clk);
    cyc++;
    check("pix_valid",  pix_valid,  q.size() != 0);
    check("pix_data",   pix_data,   (q.size() != 0) ? q[0] : 16'h0000);
    check("busy",       busy,       m_busy);
    check("frame_done", frame_done, m_done);
    check("underflow",  underflow,  m_uf);
    push_now  = 0;
    push_word = '0;
    saw_read  = reading;
    if (reading) begin
      check("read_addr", addr, 20'(m_base + m_issued));
      check("read_in_frame", m_busy && (m_issued < FW_A), 1);
      if (tput_mode && m_issued > 0) check("read_gap", cyc - last_read_cyc, 2);
      last_read_cyc = cyc;
      m_addr    = 20'(m_base + m_issued);
      push_word = sram_word(m_addr);
      push_now  = 1;
      m_issued++;
    end else begin
      check("addr_hold", addr, m_addr);
    end
    start  = s;
    sel    = bs;
    pix_rd = rd;
    if (m_done) begin
      m_done = 0; m_busy = 0; m_frames++;
    end else if (s && !m_busy) begin
      m_busy = 1; m_base = int'(bs) * FW_A; m_issued = 0; m_pushed = 0; m_uf = 0;
    end
    if (rd && q.size() == 0) m_uf = 1;
    if (rd && q.size() != 0) void'(q.pop_front());
    if (push_now) begin
      check("no_overflow", q.size() < DEPTH, 1);
      q.push_back(push_word);
      m_pushed++;
      if (m_pushed == FW_A) m_done = 1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 64) begin
      cycle(1'b0, 2'd0, 1'b1);
      n++;
    end
  endtask

  task automatic run_frame(input logic [1:0] bs, input int rd_pct, input bit mid_start);
    int n  = 0;
    int f0 = m_frames;
    cycle(1'b1, bs, 1'b0);
    while (m_busy && n < 1000) begin
      cycle(mid_start && n == 15, ~bs, $urandom_range(0, 99) < rd_pct);
      n++;
    end
    check("frame_done_count", m_frames - f0, 1);
    check("frame_words", m_pushed, FW_A);
    if (rd_pct >= 100) check("frame_cycles", n, 2 * FW_A + 1);
    drain();
  endtask

  task automatic full_geometry_test();
    bit found;
    for (int s = 0; s < 4; s++) begin
      @(negedge Clk); start_d = 1'b1; sel_d = 2'(s);
      @(negedge Clk); start_d = 1'b0; sel_d = 2'(3 - s);
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
        if (reading_d) found = 1; else @(negedge Clk);
      end
      check("full_first_seen", found, 1);
      check("full_first_addr", addr_d, 20'(s * 153600));
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
        @(negedge Clk);
        if (reading_d) found = 1;
      end
      check("full_second_seen", found, 1);
      check("full_second_addr", addr_d, 20'(s * 153600 + 1));
      check("full_underflow", underflow_d, 1);
      check("full_no_done", frame_done_d, 0);
      #2 Reset_n = 1'b0;
      #1 check("full_rst_busy", busy_d, 0);
      check("full_rst_addr", addr_d, 0);
      @(negedge Clk); Reset_n = 1'b1;
    end
  endtask

  initial begin
    bit found;
    int n;
    seed    = 16'($urandom);
    Reset_n = 1'b0;
    start = 0; sel = 0; pix_rd = 0;
    start_d = 0; sel_d = 0; pix_rd_d = 1;
    cyc = 0; last_read_cyc = 0; m_frames = 0; m_base = 0; tput_mode = 0;
    model_clear();
    #1 reset_values();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;

    full_geometry_test();

    // Pop on empty sets the sticky flag; the next accepted start clears it.
    cycle(1'b0, 2'd0, 1'b1);
    repeat (3) cycle(1'b0, 2'd0, 1'b0);

    // Consumer always ready: one word per two cycles.
    tput_mode = 1;
    run_frame(2'd2, 100, 0);
    tput_mode = 0;

    // Consumer stalled: reads must stop with the FIFO full, then resume.
    cycle(1'b1, 2'd1, 1'b0);
    repeat (60) cycle(1'b0, 2'd3, 1'b0);
    check("stall_fill", m_pushed, DEPTH);
    check("stall_busy", busy, 1);
    check("stall_no_read", reading, 0);
    found = 0;
    repeat (3) begin
      cycle(1'b0, 2'd0, 1'b1);
      if (saw_read) found = 1;
    end
    check("stall_resume", found, 1);
    n = 0;
    while (m_busy && n < 600) begin
      cycle(n == 8, 2'd3, $urandom_range(0, 99) < 50);
      n++;
    end
    check("stall_frame_end", m_pushed, FW_A);
    drain();

    // Random frames, each with an ignored mid-frame start on another background.
    for (int f = 0; f < 3; f++)
      run_frame(2'($urandom_range(0, 3)), int'($urandom_range(20, 90)), 1);

    // Reset while a read is in its capture cycle, then restart cleanly.
    cycle(1'b1, 2'd3, 1'b0);
    found = 0;
    n = 0;
    while (!found && n < 60) begin
      cycle(1'b0, 2'd3, 1'($urandom_range(0, 1)));
      if (saw_read && m_issued > 3) found = 1;
      n++;
    end
    check("capture_seen", found, 1);
    #2 Reset_n = 1'b0;
    start = 0; pix_rd = 0;
    #1 reset_values();
    model_clear();
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) cycle(1'b0, 2'd3, 1'b0);
    run_frame(2'd3, 60, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bg_frame_reader.md
BG_FRAME_READER -- requirements
Module: bg_frame_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, pixel-word FIFO depth (power of 2, >=4).
REQ-002 Parameter FRAME_WORDS, default 153600, 16-bit SRAM words per background (640x480, 2 pixels per word).
REQ-003 Clk  in  1  single clock; all state SHALL change on posedge Clk.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse requesting a frame read (vsync-derived).
REQ-006 BG_Sel  in  2  background select, sampled only on an accepted start.
REQ-007 reading  out  1  SRAM read strobe; the SRAM returns data combinationally on DATA_IN.
REQ-008 ADDR  out  20  SRAM word address.
REQ-009 DATA_IN  in  16  SRAM read data.
REQ-010 pix_rd  in  1  consumer pop request.
REQ-011 pix_data  out  16  FIFO head word, valid when pix_valid=1.
REQ-012 pix_valid  out  1  FIFO not empty.
REQ-013 busy  out  1  frame read in progress (state not IDLE).
REQ-014 frame_done  out  1  one-cycle pulse after the last word is pushed.
REQ-015 underflow  out  1  sticky flag; set on pix_rd while pix_valid=0.

Function
REQ-016 Base address = BG_Sel x FRAME_WORDS: 0, 153600, 307200, 460800; all values fit in 20 bits.
REQ-017 States: IDLE, ISSUE, CAPTURE, DONE.
REQ-018 IDLE: on start=1, latch base, clear word counter, go to ISSUE; otherwise hold.
REQ-019 start while busy=1 SHALL be ignored, with no restart and no change to the latched base.
REQ-020 ISSUE: if FIFO count + pop-adjusted in-flight <= FIFO_DEPTH-1, assert reading=1 with ADDR=base+counter, go to CAPTURE; otherwise stall in ISSUE with reading=0.
REQ-021 CAPTURE: push DATA_IN (registered on this edge) into the FIFO and increment the counter; if the counter was FRAME_WORDS-1, go to DONE, else go to ISSUE.
REQ-022 Throughput SHALL be one word per 2 cycles when the FIFO is not full.
REQ-023 DONE: pulse frame_done=1 for exactly one cycle, then go to IDLE.
REQ-024 reading SHALL be 1 only in ISSUE cycles that issue a read; ADDR SHALL hold its last value otherwise.
REQ-025 The FIFO SHALL never overflow; the ISSUE admission check guarantees it.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-027 A pop on an empty FIFO SHALL be discarded: count stays 0 and underflow is set.
REQ-028 Counter width is 18 bits; address arithmetic is 20-bit unsigned with no wrap inside a frame.
REQ-029 FIFO latency: a word pushed at edge N SHALL appear on pix_data/pix_valid after edge N (zero bubble).

Reset
REQ-030 Reset_n=0 SHALL asynchronously force IDLE, empty the FIFO, and drive reading=0, ADDR=0, busy=0, frame_done=0, pix_valid=0, pix_data=0, underflow=0.
REQ-031 Reset mid-frame SHALL abort the read; no frame_done pulse; a fresh start is required afterwards.
REQ-032 underflow SHALL be cleared only by reset or by an accepted start.

Structure
REQ-033 Package tron_pkg SHALL hold the FSM state enum, the FRAME_WORDS constant, and the background-base constant table.
REQ-034 The FIFO SHALL be a sub-module, pixel_fifo (parameterised depth and width, count output), instantiated once.

Verification
REQ-035 Reset, then start with BG_Sel=2 and pix_rd held at 1 -> first ADDR=307200, last ADDR=460799, 153600 reads, one frame_done, underflow=0.
REQ-036 Use FRAME_WORDS=8 with pix_rd=0 -> exactly FIFO_DEPTH... capped: with depth 16, 8 words pushed and reading=0 after the 8th; raise pix_rd -> words popped in address order.
REQ-037 Use FRAME_WORDS=64 with pix_rd=0 -> reads stall at FIFO count 16 (no overflow); release pix_rd -> reading resumes within 2 cycles.
REQ-038 Pulse start mid-frame with a different BG_Sel -> ignored; ADDR continues from the original base.
REQ-039 pix_rd=1 with the FIFO empty -> underflow=1 and stays set; next accepted start clears it.
REQ-040 Drop Reset_n during CAPTURE -> immediate IDLE, outputs at reset values, no frame_done; a new start restarts at the base.
